// File: rtl/full_adder_gate_pkg.sv
// Shared constants for the NAND-network full adder cell.
`timescale 1ns/1ps
package full_adder_gate_pkg;
  localparam logic RST_VAL_DEFAULT = 1'b0;
  localparam int   NAND_COUNT      = 9;

  // Arithmetic reference, used only by the optional self-check (never by the datapath).
  function automatic logic [1:0] fa_ref(input logic a, input logic b, input logic c);
    return 2'(a) + 2'(b) + 2'(c);
  endfunction
endpackage

// File: rtl/full_adder_gate_nand2.sv
// Two-input NAND leaf; the adder datapath is built only from these.
`timescale 1ns/1ps
module nand2_cell (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

// File: rtl/full_adder_gate.sv
// 1-bit full adder as a 9-NAND network with combinational and registered outputs.
// Optional FULL_ADDER_GATE_CHECK_EN adds a sticky arithmetic self-check flag err_q.
`timescale 1ns/1ps
module full_adder_gate
  import full_adder_gate_pkg::*;
#(
  parameter logic RST_VAL = RST_VAL_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic inA,
  input  logic inB,
  input  logic Cin,
  output logic outS2,
  output logic Cout0,
  output logic outS_q,
`ifdef FULL_ADDER_GATE_CHECK_EN
  output logic Cout_q,
  output logic err_q
`else
  output logic Cout_q
`endif
);
  logic w_n1, w_n2, w_n3, w_s1;
  logic w_n5, w_n6, w_n7, w_s2, w_cout;
  logic r_s_q, r_cout_q;

  // First half adder: A ^ B, with n1 = ~(A&B) reused by the carry gate.
  nand2_cell u_n1 (.a(inA),  .b(inB),  .y(w_n1));
  nand2_cell u_n2 (.a(inA),  .b(w_n1), .y(w_n2));
  nand2_cell u_n3 (.a(inB),  .b(w_n1), .y(w_n3));
  nand2_cell u_n4 (.a(w_n2), .b(w_n3), .y(w_s1));

  // Second half adder: S1 ^ Cin, with n5 = ~(S1&Cin) feeding the carry gate.
  nand2_cell u_n5 (.a(w_s1), .b(Cin),  .y(w_n5));
  nand2_cell u_n6 (.a(w_s1), .b(w_n5), .y(w_n6));
  nand2_cell u_n7 (.a(Cin),  .b(w_n5), .y(w_n7));
  nand2_cell u_n8 (.a(w_n6), .b(w_n7), .y(w_s2));

  // Carry = (A&B) | (S1&Cin) expressed as a NAND of the two inverted terms.
  nand2_cell u_n9 (.a(w_n1), .b(w_n5), .y(w_cout));

  assign outS2 = w_s2;
  assign Cout0 = w_cout;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_q    <= RST_VAL;
      r_cout_q <= RST_VAL;
    end else begin
      r_s_q    <= w_s2;
      r_cout_q <= w_cout;
    end
  end

  assign outS_q = r_s_q;
  assign Cout_q = r_cout_q;

`ifdef FULL_ADDER_GATE_CHECK_EN
  logic r_err;

  always_ff @(posedge clk) begin
    if (rst)
      r_err <= 1'b0;
    else if ({w_cout, w_s2} != fa_ref(inA, inB, Cin))
      r_err <= 1'b1;
  end

  assign err_q = r_err;
`endif
endmodule

// File: tb/tb_full_adder_gate.sv
// Self-checking bench: arithmetic model + per-cycle compare, directed sweep and random phase.
`timescale 1ns/1ps
module tb_full_adder_gate;
  logic clk = 1'b0;
  logic rst, inA, inB, Cin;
  logic outS2, Cout0, outS_q, Cout_q;
`ifdef FULL_ADDER_GATE_CHECK_EN
  logic err_q;
`endif

  int n_pass = 0;
  int n_tot  = 0;

  full_adder_gate dut (
    .clk(clk), .rst(rst), .inA(inA), .inB(inB), .Cin(Cin),
    .outS2(outS2), .Cout0(Cout0), .outS_q(outS_q),
`ifdef FULL_ADDER_GATE_CHECK_EN
    .Cout_q(Cout_q), .err_q(err_q)
`else
    .Cout_q(Cout_q)
`endif
  );

  always #500 clk = ~clk;

  // Model: outputs are just the integer sum of three bits.
  function automatic logic [1:0] sum3(input logic a, input logic b, input logic c);
    int s;
    s = int'(a) + int'(b) + int'(c);
    return s[1:0];
  endfunction

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Registered model: value seen one edge earlier, or reset value.
  logic [1:0] exp_q;
  logic q_valid = 1'b0;
  logic chk_en  = 1'b1;
  logic frc     = 1'b0;

  always @(posedge clk) begin
    if (frc) q_valid <= 1'b0;
    else if (rst) begin
      exp_q   <= 2'b00;
      q_valid <= 1'b1;
    end else exp_q <= sum3(inA, inB, Cin);
  end

  // Compare process: mid-cycle, inputs have been stable since well before.
  always @(negedge clk) begin
    if (chk_en) begin
      check("comb", {Cout0, outS2}, sum3(inA, inB, Cin));
      if (q_valid) check("regd", {Cout_q, outS_q}, exp_q);
    end
  end

  task automatic drive(input logic a, input logic b, input logic c);
    inA = a; inB = b; Cin = c;
  endtask

  initial begin
    logic [7:0] tbl_s, tbl_c;
    logic [2:0] v;
    tbl_s = 8'b1001_0110;  // index {Cin,B,A}
    tbl_c = 8'b1110_1000;
    rst = 1'b1;
    drive(0, 0, 0);
    repeat (2) @(posedge clk);
    #1 check("reset_q", {Cout_q, outS_q}, 2'b00);

    // Directed exhaustive sweep, each vector checked 100 units after the change.
    #199 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      drive(v[0], v[1], v[2]);
      #100 check($sformatf("sweep%0d", i), {Cout0, outS2}, {tbl_c[i], tbl_s[i]});
      @(posedge clk);
      #200;
    end

    // Registered path holds one cycle.
    drive(1, 1, 1);
    @(posedge clk);
    #1 check("reg_111", {Cout_q, outS_q}, 2'b11);
    #199 drive(0, 0, 0);
    #100 check("reg_hold", {Cout_q, outS_q}, 2'b11);
    @(posedge clk);
    #1 check("reg_000", {Cout_q, outS_q}, 2'b00);

    // Reset mid-operation: registers clear, combinational path untouched.
    #199 drive(1, 1, 0);
    rst = 1'b1;
    #100 check("rst_comb_pre", {Cout0, outS2}, 2'b10);
    @(posedge clk);
    #1 check("rst_q", {Cout_q, outS_q}, 2'b00);
    check("rst_comb_post", {Cout0, outS2}, 2'b10);
    #199 rst = 1'b0;
    @(posedge clk);
    #1 check("post_rst_q", {Cout_q, outS_q}, 2'b10);

    // Random phase with occasional reset.
    for (int i = 0; i < 300; i++) begin
      #199;
      drive(1'($urandom), 1'($urandom), 1'($urandom));
      rst = ($urandom_range(0, 19) == 0);
      @(posedge clk);
      #1;
    end
    #199 rst = 1'b0;
    @(posedge clk);

`ifdef FULL_ADDER_GATE_CHECK_EN
    rst = 1'b1;
    @(posedge clk);
    #200 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      v = 3'(i % 8);
      drive(v[0], v[1], v[2]);
      @(posedge clk);
      #200;
    end
    check("err_clean", {1'b0, err_q}, 2'b00);
    // A=1,B=0,Cin=1 with n5 stuck high makes the sum wrong.
    chk_en = 1'b0;
    frc = 1'b1;
    drive(1, 0, 1);
    force dut.w_n5 = 1'b1;
    @(posedge clk);
    #200 release dut.w_n5;
    drive(0, 0, 0);
    #100 check("err_set", {1'b0, err_q}, 2'b01);
    @(posedge clk);
    #1 check("err_sticky", {1'b0, err_q}, 2'b01);
    #199 rst = 1'b1;
    frc = 1'b0;
    @(posedge clk);
    #1 check("err_clear", {1'b0, err_q}, 2'b00);
    #199 rst = 1'b0;
    chk_en = 1'b1;
    @(posedge clk);
`endif

    #1 $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
